// File: rtl/muldiv_pkg.sv
// Shared encodings and decode helpers for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV   = 7'b0000001;
  localparam logic [1:0] ALU_CLASS_RTYPE = 2'b00;

  // Upper half of the funct3 space is the divide/remainder group.
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // Operand A is signed for MUL, MULH, MULHSU, DIV and REM.
  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // Operand B is signed for MUL, MULH, DIV and REM (not MULHSU).
  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative RV32M execute unit: shift-add multiply / restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up on completion.
module alu_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [1:0]      alu_ctrl_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            is_m_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;          // negate product / quotient
  logic            neg_rem_q, neg_rem_d;  // negate remainder (dividend sign)
  logic [XLEN-1:0] opnd_q, opnd_d;        // multiplicand or divisor magnitude
  logic [XLEN-1:0] hi_q, hi_d;            // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;            // multiplier bits / quotient bits
  logic [XLEN-1:0] result_q, result_d;
  logic            done_q, done_d;

  logic            start;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_by_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_shift;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_sub;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

  assign is_m_o   = (alu_ctrl_i == ALU_CLASS_RTYPE) && (funct7_i == FUNCT7_MULDIV);
  assign start    = valid_i && is_m_o && !flush_i;
  assign stall_o  = ((state_q == IDLE) && start) || (state_q == BUSY);
  assign done_o   = done_q;
  assign result_o = result_q;

  // Operand decode: magnitudes and single-cycle special-case detection.
  always_comb begin
    a_neg       = is_signed_a(funct3_i) && rs1_i[XLEN-1];
    b_neg       = is_signed_b(funct3_i) && rs2_i[XLEN-1];
    a_mag       = a_neg ? ('0 - rs1_i) : rs1_i;
    b_mag       = b_neg ? ('0 - rs2_i) : rs2_i;
    div_by_zero = is_div(funct3_i) && (rs2_i == '0);
    div_ovf     = is_div(funct3_i) && is_signed_b(funct3_i) &&
                  (rs1_i == MOST_NEG) && (rs2_i == '1);
    special_res = '0;
    if (div_by_zero) begin
      special_res = funct3_i[1] ? rs1_i : '1;
    end else if (div_ovf) begin
      special_res = funct3_i[1] ? '0 : MOST_NEG;
    end
  end

  // One iteration of the datapath plus end-of-operation sign fix-up.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, opnd_q & {XLEN{lo_q[0]}}};
    rem_shift = {hi_q, lo_q[XLEN-1]};
    rem_ge    = rem_shift >= {1'b0, opnd_q};
    // Only used when rem_ge holds, so the difference always fits in XLEN bits.
    rem_sub   = rem_shift[XLEN-1:0] - opnd_q;
    if (is_div(op_q)) begin
      step_hi = rem_ge ? rem_sub : rem_shift[XLEN-1:0];
      step_lo = {lo_q[XLEN-2:0], rem_ge};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
    prod     = {step_hi, step_lo};
    prod_fix = neg_q ? ('0 - prod) : prod;
    quot_fix = neg_q ? ('0 - step_lo) : step_lo;
    rem_fix  = neg_rem_q ? ('0 - step_hi) : step_hi;
    case (op_q)
      F3_MUL:                    final_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:           final_res = quot_fix;
      default:                   final_res = rem_fix;
    endcase
  end

  // Control FSM next-state; flush overrides start and BUSY completion.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    result_d  = result_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = funct3_i;
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (div_by_zero || div_ovf) begin
            result_d = special_res;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            cnt_d   = CW'(XLEN - 1);
            hi_d    = '0;
            state_d = BUSY;
            if (is_div(funct3_i)) begin
              opnd_d = b_mag;
              lo_d   = a_mag;
            end else begin
              opnd_d = a_mag;
              lo_d   = b_mag;
            end
          end
        end
      end
      BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          result_d = final_res;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: expected results queued at issue, compared at done.
module tb_alu_muldiv;
  import muldiv_pkg::*;

  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  f3 = '0;
  logic [6:0]  f7 = '0;
  logic [1:0]  ctrl = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        is_m, stall, done;
  logic [31:0] result;

  int checks = 0;
  int passed = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    string       name;
    logic [31:0] exp;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(XLEN)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .flush_i(flush),
    .funct3_i(f3), .funct7_i(f7), .alu_ctrl_i(ctrl),
    .rs1_i(a), .rs2_i(b),
    .is_m_o(is_m), .stall_o(stall), .done_o(done), .result_o(result)
  );

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, p;
    logic [63:0] ux, uy, pu;
    logic signed [31:0] sx32, sy32, q;
    sx = {{32{x[31]}}, x}; sy = {{32{y[31]}}, y};
    ux = {32'b0, x};       uy = {32'b0, y};
    sx32 = x; sy32 = y;
    case (op)
      F3_MUL:    begin p = sx * sy; return p[31:0]; end
      F3_MULH:   begin p = sx * sy; return p[63:32]; end
      F3_MULHSU: begin p = sx * $signed(uy); return p[63:32]; end
      F3_MULHU:  begin pu = ux * uy; return pu[63:32]; end
      F3_DIV: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
        q = sx32 / sy32; return q;
      end
      F3_DIVU: return (y == 0) ? 32'hFFFFFFFF : x / y;
      F3_REM: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
        q = sx32 % sy32; return q;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Drive one M instruction and observe it until done (bounded).
  task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat, output int stalls);
    @(negedge clk);
    valid = 1'b1; f3 = op; f7 = FUNCT7_MULDIV; ctrl = ALU_CLASS_RTYPE; a = x; b = y;
    lat = -1; stalls = 0; res = 'x;
    for (int c = 0; c < 100; c++) begin
      if (c > 0) begin
        @(negedge clk);
        valid = 1'b0;
      end
      #1;
      if (stall) stalls++;
      if (done) begin
        lat = c; res = result;
        break;
      end
    end
    valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (result !== 32'h0) $display("FAIL reset_result got %h want 00000000", result); else passed++;
    checks++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [2:0]  ops [4];
    logic [31:0] xs [4], ys [4], exps [4];
    logic [31:0] res; int lat, st; exp_t e;
    ops  = '{F3_MUL, F3_MULH, F3_MULHU, F3_MULHSU};
    xs   = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    ys   = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    exps = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{$sformatf("mul%0d", i), exps[i], 33});
      do_op(ops[i], xs[i], ys[i], res, lat, st);
      e = sb_q.pop_front();
      checks++; if (res !== e.exp) $display("FAIL %s_result got %h want %h", e.name, res, e.exp); else passed++;
      checks++; if (lat !== e.lat) $display("FAIL %s_latency got %0d want %0d", e.name, lat, e.lat); else passed++;
      checks++; if (st !== e.lat) $display("FAIL %s_stall_cycles got %0d want %0d", e.name, st, e.lat); else passed++;
      last_res = e.exp;
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops [4];
    logic [31:0] xs [4], ys [4], exps [4];
    logic [31:0] res; int lat, st; exp_t e;
    ops  = '{F3_DIV, F3_REM, F3_DIVU, F3_REMU};
    xs   = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    ys   = '{32'd2, 32'd2, 32'd7, 32'd7};
    exps = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{$sformatf("div%0d", i), exps[i], 33});
      do_op(ops[i], xs[i], ys[i], res, lat, st);
      e = sb_q.pop_front();
      checks++; if (res !== e.exp) $display("FAIL %s_result got %h want %h", e.name, res, e.exp); else passed++;
      checks++; if (lat !== e.lat) $display("FAIL %s_latency got %0d want %0d", e.name, lat, e.lat); else passed++;
      checks++; if (st !== e.lat) $display("FAIL %s_stall_cycles got %0d want %0d", e.name, st, e.lat); else passed++;
      last_res = e.exp;
    end
  endtask

  task automatic test_special();
    logic [2:0]  ops [4];
    logic [31:0] xs [4], ys [4], exps [4];
    logic [31:0] res; int lat, st; exp_t e;
    ops  = '{F3_DIVU, F3_REM, F3_REM, F3_DIV};
    xs   = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    ys   = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    exps = '{32'hFFFFFFFF, 32'd5, 32'd0, 32'h80000000};
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{$sformatf("special%0d", i), exps[i], 1});
      do_op(ops[i], xs[i], ys[i], res, lat, st);
      e = sb_q.pop_front();
      checks++; if (res !== e.exp) $display("FAIL %s_result got %h want %h", e.name, res, e.exp); else passed++;
      checks++; if (lat !== e.lat) $display("FAIL %s_latency got %0d want %0d", e.name, lat, e.lat); else passed++;
      checks++; if (st !== e.lat) $display("FAIL %s_stall_cycles got %0d want %0d", e.name, st, e.lat); else passed++;
      last_res = e.exp;
    end
  endtask

  task automatic test_flush();
    logic [31:0] res; int lat, st; exp_t e; int seen_done;
    @(negedge clk);
    valid = 1'b1; f3 = F3_DIV; f7 = FUNCT7_MULDIV; ctrl = ALU_CLASS_RTYPE; a = 32'd1000; b = 32'd7;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      valid = 1'b0;
    end
    #1;
    checks++; if (stall !== 1'b1) $display("FAIL flush_busy_stall got %b want 1", stall); else passed++;
    flush = 1'b1;
    @(posedge clk); #1;
    checks++; if (stall !== 1'b0) $display("FAIL flush_stall got %b want 0", stall); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL flush_done got %b want 0", done); else passed++;
    checks++; if (result !== last_res) $display("FAIL flush_result got %h want %h", result, last_res); else passed++;
    @(negedge clk);
    flush = 1'b0;
    seen_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done || stall) seen_done++;
    end
    checks++; if (seen_done !== 0) $display("FAIL flush_quiet got %0d active cycles want 0", seen_done); else passed++;
    sb_q.push_back('{"post_flush_mulhu", 32'd0, 33});
    do_op(F3_MULHU, 32'd3, 32'd5, res, lat, st);
    e = sb_q.pop_front();
    checks++; if (res !== e.exp) $display("FAIL %s_result got %h want %h", e.name, res, e.exp); else passed++;
    checks++; if (lat !== e.lat) $display("FAIL %s_latency got %0d want %0d", e.name, lat, e.lat); else passed++;
    last_res = e.exp;
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; int lat, st; exp_t e;
    sb_q.push_back('{"pre_reset_mul", 32'd21, 33});
    do_op(F3_MUL, 32'd7, 32'd3, res, lat, st);
    e = sb_q.pop_front();
    checks++; if (res !== e.exp) $display("FAIL %s_result got %h want %h", e.name, res, e.exp); else passed++;
    @(negedge clk);
    valid = 1'b1; f3 = F3_MUL; f7 = FUNCT7_MULDIV; ctrl = ALU_CLASS_RTYPE; a = 32'd9; b = 32'd9;
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (result !== 32'h0) $display("FAIL rst_mid_result got %h want 00000000", result); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rst_mid_done got %b want 0", done); else passed++;
    checks++; if (stall !== 1'b0) $display("FAIL rst_mid_stall got %b want 0", stall); else passed++;
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
  endtask

  task automatic test_non_m();
    int active;
    @(negedge clk);
    valid = 1'b0; f3 = F3_MUL; f7 = FUNCT7_MULDIV; ctrl = ALU_CLASS_RTYPE; #1;
    checks++; if (is_m !== 1'b1) $display("FAIL is_m_rtype got %b want 1", is_m); else passed++;
    ctrl = 2'b01; #1;
    checks++; if (is_m !== 1'b0) $display("FAIL is_m_iclass got %b want 0", is_m); else passed++;
    @(negedge clk);
    valid = 1'b1; f7 = 7'b0000000; ctrl = ALU_CLASS_RTYPE; a = 32'd6; b = 32'd3; #1;
    checks++; if (is_m !== 1'b0) $display("FAIL is_m_base got %b want 0", is_m); else passed++;
    checks++; if (stall !== 1'b0) $display("FAIL non_m_stall got %b want 0", stall); else passed++;
    active = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (done || stall) active++;
    end
    checks++; if (active !== 0) $display("FAIL non_m_quiet got %0d active cycles want 0", active); else passed++;
    valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [2:0] op; logic [31:0] x, y, res; int lat, st; exp_t e; int el;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 7));
      x  = $urandom;
      y  = $urandom;
      if (i % 5 == 1) y = 32'd0;
      if (i % 5 == 3) begin x = 32'h80000000; y = 32'hFFFFFFFF; end
      el = 33;
      if (op[2] && (y == 0 || ((op == F3_DIV || op == F3_REM) && x == 32'h80000000 && y == 32'hFFFFFFFF)))
        el = 1;
      sb_q.push_back('{$sformatf("b2b%0d_f3_%0d", i, op), model(op, x, y), el});
      do_op(op, x, y, res, lat, st);
      e = sb_q.pop_front();
      checks++; if (res !== e.exp) $display("FAIL %s_result got %h want %h", e.name, res, e.exp); else passed++;
      checks++; if (lat !== e.lat) $display("FAIL %s_latency got %0d want %0d", e.name, lat, e.lat); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_reset_mid();
    test_non_m();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
